gate_net_scheduler: RTL and testbench



---
 rtl/gate_net_scheduler_pkg.sv | 15 +
 rtl/rr_arb2.sv | 36 +++
 rtl/gate_net_scheduler.sv | 115 +++++++++++
 tb/tb_gate_net_scheduler.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_net_scheduler_pkg.sv
// Shared definitions for the gate network scheduler: FSM encoding, default
// settle interval and requester index constants.
package gate_net_scheduler_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SETTLE = 1'b1
  } state_t;

  localparam int DEF_SETTLE_CYCLES = 6;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin arbiter. Grant is one-hot and combinational; the
// last_grant register records which requester won the most recent grant.
module rr_arb2
  import gate_net_scheduler_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  logic last_grant;

  always_comb begin
    grant = 2'b00;
    if (en) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        // On a tie the requester that did not win last time is served.
        2'b11:   grant = (last_grant == REQ1) ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= REQ1;
    end else if (|grant) begin
      last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/gate_net_scheduler.sv
// Time-shares one combinational gate network between two requesters: grants
// round-robin, drives A/B/C, waits SETTLE_CYCLES, then returns sampled {D,E}.
module gate_net_scheduler
  import gate_net_scheduler_pkg::*;
#(
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int CNT_W         = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [2:0] req0_abc,
  output logic       req0_ready,
  output logic       rsp0_valid,
  output logic [1:0] rsp0_de,
  input  logic       req1_valid,
  input  logic [2:0] req1_abc,
  output logic       req1_ready,
  output logic       rsp1_valid,
  output logic [1:0] rsp1_de,
  output logic       net_a,
  output logic       net_b,
  output logic       net_c,
  input  logic       net_d,
  input  logic       net_e,
  output logic       busy
);

  // Handshake: a request is accepted on a rising edge where valid & ready;
  // ready is only ever raised in IDLE. Responses are single-cycle rsp_valid
  // pulses with no backpressure.

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             owner;
  logic             arb_en;
  logic [1:0]       grant;
  logic             accept;
  logic             sample;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .en    (arb_en),
    .req   ({req1_valid, req0_valid}),
    .grant (grant)
  );

  assign accept = |grant;
  assign sample = (state == ST_SETTLE) && (cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (accept) state_nxt = ST_SETTLE;
      ST_SETTLE: if (cnt == '0) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    arb_en     = (state == ST_IDLE);
    busy       = (state == ST_SETTLE);
    req0_ready = grant[0];
    req1_ready = grant[1];
  end

  // Network inputs change only on an accept edge so they stay glitch-free
  // for the whole settle window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      net_a <= 1'b0;
      net_b <= 1'b0;
      net_c <= 1'b0;
      owner <= REQ0;
      cnt   <= '0;
    end else if (accept) begin
      {net_a, net_b, net_c} <= grant[1] ? req1_abc : req0_abc;
      owner                 <= grant[1];
      cnt                   <= CNT_W'(SETTLE_CYCLES - 1);
    end else if ((state == ST_SETTLE) && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_de    <= 2'b00;
      rsp1_de    <= 2'b00;
    end else begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      if (sample) begin
        if (owner == REQ1) begin
          rsp1_valid <= 1'b1;
          rsp1_de    <= {net_d, net_e};
        end else begin
          rsp0_valid <= 1'b1;
          rsp0_de    <= {net_d, net_e};
        end
      end
    end
  end

endmodule

// File: tb/tb_gate_net_scheduler.sv
// Bench for gate_net_scheduler: delayed gate network model, directed requests
// with hand-computed {D,E}, and a scoreboard checking response value and cycle.
`timescale 1ns/1ps
module tb_gate_net_scheduler;

  localparam int S  = 6;
  localparam int S4 = 4;
  localparam int W  = 18;  // {expected response cycle[15:0], expected de[1:0]}

  logic       clk, rst;
  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  logic [2:0] req0_abc, req1_abc;
  logic       rsp0_valid, rsp1_valid, busy;
  logic [1:0] rsp0_de, rsp1_de;
  logic       net_a, net_b, net_c, net_d, net_e;

  logic       r0v4, r1v4, r0r4, r1r4, s0v4, s1v4, busy4;
  logic [2:0] r0abc4, r1abc4;
  logic [1:0] s0de4, s1de4;
  logic       na4, nb4, nc4, nd4_raw, ne4_raw, corrupt;

  int checks = 0;
  int failures = 0;
  logic [15:0] cyc = '0;
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];

  gate_net_scheduler #(.SETTLE_CYCLES(S), .CNT_W(4)) u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_abc(req0_abc), .req0_ready(req0_ready),
    .rsp0_valid(rsp0_valid), .rsp0_de(rsp0_de),
    .req1_valid(req1_valid), .req1_abc(req1_abc), .req1_ready(req1_ready),
    .rsp1_valid(rsp1_valid), .rsp1_de(rsp1_de),
    .net_a(net_a), .net_b(net_b), .net_c(net_c),
    .net_d(net_d), .net_e(net_e), .busy(busy)
  );

  gate_net_scheduler #(.SETTLE_CYCLES(S4), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .req0_valid(r0v4), .req0_abc(r0abc4), .req0_ready(r0r4),
    .rsp0_valid(s0v4), .rsp0_de(s0de4),
    .req1_valid(r1v4), .req1_abc(r1abc4), .req1_ready(r1r4),
    .rsp1_valid(s1v4), .rsp1_de(s1de4),
    .net_a(na4), .net_b(nb4), .net_c(nc4),
    .net_d(nd4_raw ^ corrupt), .net_e(ne4_raw ^ corrupt), .busy(busy4)
  );

  // Gate networks: D = (A&B) | ~C, E = ~C, with transport delay.
  always @(net_a, net_b, net_c) begin
    net_d <= #50 (net_a & net_b) | ~net_c;
    net_e <= #50 ~net_c;
  end

  always @(na4, nb4, nc4) begin
    nd4_raw <= #20 (na4 & nb4) | ~nc4;
    ne4_raw <= #20 ~nc4;
  end

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 16'd1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input int r, input logic [2:0] abc, input logic [1:0] de, input bit push);
    bit got;
    got = 1'b0;
    @(negedge clk);
    if (r == 0) begin req0_valid = 1'b1; req0_abc = abc; end
    else        begin req1_valid = 1'b1; req1_abc = abc; end
    for (int n = 0; n < 50; n++) begin
      #1;
      if ((r == 0 && req0_ready) || (r == 1 && req1_ready)) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("ready_seen", 32'(got), 32'd1);
    chk("ready_other", 32'((r == 0) ? req1_ready : req0_ready), 32'd0);
    if (push) begin
      if (r == 0) exp_q0.push_back({cyc + 16'd1 + 16'(S), de});
      else        exp_q1.push_back({cyc + 16'd1 + 16'(S), de});
    end
    @(posedge clk);
    #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    chk("net_driven", 32'({net_a, net_b, net_c}), 32'(abc));
    chk("busy_settle", 32'(busy), 32'd1);
    chk("no_ready_settle", 32'({req0_ready, req1_ready}), 32'd0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(exp_q0.size() + exp_q1.size()), 32'd0);
    @(negedge clk);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (rsp0_valid) begin
        if (exp_q0.size() == 0) chk("rsp0_unexpected", 32'd1, 32'd0);
        else begin
          logic [W-1:0] e;
          e = exp_q0.pop_front();
          chk("rsp0_de", 32'(rsp0_de), 32'(e[1:0]));
          chk("rsp0_cycle", 32'(cyc), 32'(e[W-1:2]));
        end
      end
      if (rsp1_valid) begin
        if (exp_q1.size() == 0) chk("rsp1_unexpected", 32'd1, 32'd0);
        else begin
          logic [W-1:0] e;
          e = exp_q1.pop_front();
          chk("rsp1_de", 32'(rsp1_de), 32'(e[1:0]));
          chk("rsp1_cycle", 32'(cyc), 32'(e[W-1:2]));
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; req0_abc = '0; req1_abc = '0;
    r0v4 = 1'b0; r1v4 = 1'b0; r0abc4 = '0; r1abc4 = '0; corrupt = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_net", 32'({net_a, net_b, net_c}), 32'd0);
    chk("rst_rsp", 32'({rsp0_valid, rsp1_valid, rsp0_de, rsp1_de}), 32'd0);
    chk("rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
    rst = 1'b0;

    // Single-requester vectors
    send(0, 3'b110, 2'b11, 1'b1); drain();
    send(1, 3'b001, 2'b00, 1'b1); drain();
    send(1, 3'b111, 2'b10, 1'b1); drain();
    chk("rsp0_de_hold", 32'(rsp0_de), 32'b11);

    // Both held valid from reset: grants alternate 0,1,0,1, back-to-back
    do_reset();
    begin
      int n_acc, exp_r;
      logic [15:0] last;
      n_acc = 0; exp_r = 0; last = '0;
      @(negedge clk);
      req0_abc = 3'b110; req1_abc = 3'b111;
      req0_valid = 1'b1; req1_valid = 1'b1;
      for (int n = 0; n < 100 && n_acc < 4; n++) begin
        #1;
        if (req0_ready || req1_ready) begin
          chk("rr_onehot", 32'(req0_ready & req1_ready), 32'd0);
          chk("rr_order", 32'(req1_ready), 32'(exp_r));
          if (req1_ready) exp_q1.push_back({cyc + 16'd1 + 16'(S), 2'b10});
          else            exp_q0.push_back({cyc + 16'd1 + 16'(S), 2'b11});
          if (n_acc > 0) chk("rr_gap", 32'(cyc - last), 32'(S + 1));
          last = cyc;
          n_acc++;
          exp_r ^= 1;
          if (n_acc == 4) begin
            @(posedge clk);
            #1;
            req0_valid = 1'b0; req1_valid = 1'b0;
          end
        end
        if (n_acc < 4) @(negedge clk);
      end
      chk("rr_count", 32'(n_acc), 32'd4);
    end
    drain();

    // abc changes during settle are ignored
    send(0, 3'b110, 2'b11, 1'b1);
    req0_abc = 3'b001;
    repeat (3) begin
      @(negedge clk);
      chk("net_stable", 32'({net_a, net_b, net_c}), 32'b110);
    end
    drain();

    // Reset mid-settle at cnt==2: aborted, no response
    send(1, 3'b111, 2'b10, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_net", 32'({net_a, net_b, net_c}), 32'd0);
    chk("abort_rsp", 32'({rsp0_valid, rsp1_valid, rsp1_de}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    req0_abc = 3'b001; req1_abc = 3'b001;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("post_rst_grant", 32'({req1_ready, req0_ready}), 32'b01);
    req0_valid = 1'b0; req1_valid = 1'b0;
    send(0, 3'b001, 2'b00, 1'b1); drain();

    // SETTLE_CYCLES=4 instance: output corrupted through edge k+3
    @(negedge clk);
    r0v4 = 1'b1; r0abc4 = 3'b001; corrupt = 1'b1;
    #1;
    chk("s4_ready", 32'(r0r4), 32'd1);
    @(posedge clk);
    #1 r0v4 = 1'b0;
    repeat (3) @(posedge clk);
    #1 corrupt = 1'b0;
    @(negedge clk);
    chk("s4_not_early", 32'(s0v4), 32'd0);
    @(negedge clk);
    chk("s4_rsp_valid", 32'(s0v4), 32'd1);
    chk("s4_rsp_de", 32'(s0de4), 32'b00);
    @(negedge clk);
    chk("s4_pulse_end", 32'(s0v4), 32'd0);
    chk("s4_no_rsp1", 32'(s1v4), 32'd0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
